// File: rtl/gyro_regs_pkg.sv
// Shared constants for the gyro register-map SPI responder: register addresses,
// command-byte bit positions and the transaction state enum.
package gyro_regs_pkg;

    localparam logic [5:0] ADDR_WHO_AM_I = 6'h0F;
    localparam logic [5:0] ADDR_CTRL1    = 6'h20;
    localparam logic [5:0] ADDR_CTRL2    = 6'h21;
    localparam logic [5:0] ADDR_CTRL3    = 6'h22;
    localparam logic [5:0] ADDR_CTRL4    = 6'h23;
    localparam logic [5:0] ADDR_CTRL5    = 6'h24;
    localparam logic [5:0] ADDR_STATUS   = 6'h27;
    localparam logic [5:0] ADDR_OUT_XL   = 6'h28;
    localparam logic [5:0] ADDR_OUT_XH   = 6'h29;
    localparam logic [5:0] ADDR_OUT_YL   = 6'h2A;
    localparam logic [5:0] ADDR_OUT_YH   = 6'h2B;
    localparam logic [5:0] ADDR_OUT_ZL   = 6'h2C;
    localparam logic [5:0] ADDR_OUT_ZH   = 6'h2D;

    localparam int CMD_RW_BIT = 7;
    localparam int CMD_MS_BIT = 6;

    localparam int STATUS_ZYXDA_BIT = 3;
    localparam int STATUS_ZYXOR_BIT = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RD   = 2'd2,
        WR   = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer for one asynchronous SPI wire, with single-clk
// rise/fall pulses derived from the synchronized level.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // No reset: keeping history through rst stops a held-low ss from looking like a fresh fall.
    always_ff @(posedge clk) begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        prev_q <= sync_q[SYNC_STAGES-1];
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_gyro_responder.sv
// Mode-3 SPI slave emulating a 3-axis gyro register map, clocked entirely on clk.
// Optional STATUS register at 0x27 is built when GYRO_STATUS_REG_EN is defined.
module spi_gyro_responder
    import gyro_regs_pkg::*;
#(
    parameter logic [7:0] WHO_AM_I_VAL = 8'hD3,
    parameter int          SYNC_STAGES  = 2,
    parameter logic [7:0] CTRL1_RESET  = 8'h07
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        ss,
    input  logic        mosi,
    output logic        miso,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    input  logic        sample_valid,
    output logic [7:0]  ctrl_reg1,
    output logic        wr_strobe,
    output logic [5:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy
);

    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic ss_level_unused, ss_rise, ss_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .din(sclk), .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
        .clk(clk), .din(ss), .level(ss_level_unused), .rise(ss_rise), .fall(ss_fall)
    );
    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .din(mosi), .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_state_e  state, state_next;
    logic [2:0]  bit_cnt;
    logic [5:0]  addr;
    logic        ms;
    logic [6:0]  cmd_sr;
    logic [6:0]  shift_in;
    logic [7:0]  shift_out;
    logic [7:0]  ctrl_q [0:4];
    logic [15:0] live_x, live_y, live_z;
    logic [15:0] snap_x, snap_y, snap_z;
    logic [7:0]  cmd_byte;
    logic [7:0]  wr_byte;
    logic [7:0]  rd_byte;
    logic [7:0]  status_byte;
    logic        last_bit;
    logic [5:0]  next_addr;

    assign cmd_byte  = {cmd_sr, mosi_s};
    assign wr_byte   = {shift_in, mosi_s};
    assign last_bit  = (bit_cnt == 3'd7);
    assign next_addr = ms ? addr + 6'd1 : addr;
    assign busy      = (state != IDLE);
    assign ctrl_reg1 = ctrl_q[0];

`ifdef GYRO_STATUS_REG_EN
    logic zyxda, zyxor, status_clr;

    // Cleared as the last bit of OUT_Z_H leaves; a simultaneous new sample wins.
    assign status_clr = (state == RD) && sclk_fall && last_bit && (addr == ADDR_OUT_ZH);

    always_ff @(posedge clk) begin
        if (rst) begin
            zyxda <= 1'b0;
            zyxor <= 1'b0;
        end else if (sample_valid) begin
            zyxda <= 1'b1;
            zyxor <= ~status_clr & (zyxor | zyxda);
        end else if (status_clr) begin
            zyxda <= 1'b0;
            zyxor <= 1'b0;
        end
    end

    always_comb begin
        status_byte = 8'h00;
        status_byte[STATUS_ZYXDA_BIT] = zyxda;
        status_byte[STATUS_ZYXOR_BIT] = zyxor;
    end
`else
    assign status_byte = 8'h00;
`endif

    always_comb begin
        rd_byte = 8'h00;
        case (addr)
            ADDR_WHO_AM_I: rd_byte = WHO_AM_I_VAL;
            ADDR_CTRL1:    rd_byte = ctrl_q[0];
            ADDR_CTRL2:    rd_byte = ctrl_q[1];
            ADDR_CTRL3:    rd_byte = ctrl_q[2];
            ADDR_CTRL4:    rd_byte = ctrl_q[3];
            ADDR_CTRL5:    rd_byte = ctrl_q[4];
            ADDR_STATUS:   rd_byte = status_byte;
            ADDR_OUT_XL:   rd_byte = snap_x[7:0];
            ADDR_OUT_XH:   rd_byte = snap_x[15:8];
            ADDR_OUT_YL:   rd_byte = snap_y[7:0];
            ADDR_OUT_YH:   rd_byte = snap_y[15:8];
            ADDR_OUT_ZL:   rd_byte = snap_z[7:0];
            ADDR_OUT_ZH:   rd_byte = snap_z[15:8];
            default:       rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (ss_fall) state_next = CMD;
            CMD: begin
                if (sclk_rise && last_bit)
                    state_next = cmd_byte[CMD_RW_BIT] ? RD : WR;
            end
            RD, WR: state_next = state;
            default: state_next = IDLE;
        endcase
        if (ss_rise) state_next = IDLE;
    end

    // Shift registers carry data only; they are always reloaded before use.
    always_ff @(posedge clk) begin
        if (state == CMD && sclk_rise)
            cmd_sr <= cmd_byte[6:0];
        if (state == WR && sclk_rise)
            shift_in <= wr_byte[6:0];
        if (state == RD && sclk_fall)
            shift_out <= (bit_cnt == 3'd0) ? {rd_byte[6:0], 1'b1} : {shift_out[6:0], 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= 3'd0;
            addr      <= 6'd0;
            ms        <= 1'b0;
            miso      <= 1'b1;
            wr_strobe <= 1'b0;
            wr_addr   <= 6'd0;
            wr_data   <= 8'd0;
            ctrl_q[0] <= CTRL1_RESET;
            ctrl_q[1] <= 8'h00;
            ctrl_q[2] <= 8'h00;
            ctrl_q[3] <= 8'h00;
            ctrl_q[4] <= 8'h00;
            live_x    <= 16'd0;
            live_y    <= 16'd0;
            live_z    <= 16'd0;
            snap_x    <= 16'd0;
            snap_y    <= 16'd0;
            snap_z    <= 16'd0;
        end else begin
            wr_strobe <= 1'b0;
            if (sample_valid) begin
                live_x <= sample_x;
                live_y <= sample_y;
                live_z <= sample_z;
            end
            // A sample arriving on the same clk as ss falls goes straight into the snapshot.
            if (ss_fall) begin
                snap_x <= sample_valid ? sample_x : live_x;
                snap_y <= sample_valid ? sample_y : live_y;
                snap_z <= sample_valid ? sample_z : live_z;
            end
            case (state)
                IDLE: begin
                    bit_cnt <= 3'd0;
                    miso    <= 1'b1;
                end
                CMD: begin
                    if (sclk_rise) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (last_bit) begin
                            addr <= cmd_byte[5:0];
                            ms   <= cmd_byte[CMD_MS_BIT];
                        end
                    end
                end
                RD: begin
                    if (sclk_fall) begin
                        miso    <= (bit_cnt == 3'd0) ? rd_byte[7] : shift_out[7];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (last_bit) addr <= next_addr;
                    end
                end
                WR: begin
                    if (sclk_rise) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (last_bit) begin
                            wr_strobe <= 1'b1;
                            wr_addr   <= addr;
                            wr_data   <= wr_byte;
                            addr      <= next_addr;
                            case (addr)
                                ADDR_CTRL1: ctrl_q[0] <= wr_byte;
                                ADDR_CTRL2: ctrl_q[1] <= wr_byte;
                                ADDR_CTRL3: ctrl_q[2] <= wr_byte;
                                ADDR_CTRL4: ctrl_q[3] <= wr_byte;
                                ADDR_CTRL5: ctrl_q[4] <= wr_byte;
                                default: ;
                            endcase
                        end
                    end
                end
                default: ;
            endcase
            if (ss_rise) miso <= 1'b1;
        end
    end

endmodule
